// File: rtl/pmem_pkg.sv
// Shared types for the pmem responder: FSM state encoding, read-length codes
// and small helpers used for request checking.
package pmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] LEN_BYTE = 3'd1;
  localparam logic [2:0] LEN_HALF = 3'd2;
  localparam logic [2:0] LEN_WORD = 3'd4;

  function automatic logic len_legal(input logic [2:0] len);
    return (len == LEN_BYTE) || (len == LEN_HALF) || (len == LEN_WORD);
  endfunction

  // Index of the highest set bit; only meaningful for a non-zero mask.
  function automatic logic [1:0] mask_top(input logic [3:0] m);
    logic [1:0] t;
    t = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) t = 2'(i);
    end
    return t;
  endfunction

endpackage

// File: rtl/pmem_lane_align.sv
// Byte-lane shifter: moves write data/mask up to the addressed byte offset and
// extracts a zero-extended 1/2/4-byte read value from a storage word.
module pmem_lane_align
  import pmem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  len,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic [31:0] word,
  output logic [31:0] wdata_sh,
  output logic [3:0]  wmask_sh,
  output logic [31:0] rdata
);

  logic [31:0] rshift;

  always_comb begin
    wdata_sh = wdata << {off, 3'b000};
    wmask_sh = wmask << off;
    rshift   = word >> {off, 3'b000};
    case (len)
      LEN_BYTE: rdata = {24'd0, rshift[7:0]};
      LEN_HALF: rdata = {16'd0, rshift[15:0]};
      default:  rdata = rshift;
    endcase
  end

endmodule

// File: rtl/pmem_responder.sv
// Simple memory responder: one outstanding request, fixed extra latency,
// byte-granular writes and zero-extended reads over a register-array store.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | req_ready high, waiting for a request
// ST_WAIT | request latched, counting down the configured latency
// ST_RESP | response presented, held until rsp_ready
module pmem_responder
  import pmem_pkg::*;
#(
  parameter logic [31:0] BASE        = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_len,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT_LOAD  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_wen;
  logic [31:0] lat_addr;
  logic [2:0]  lat_len;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wmask;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        use_live;
  logic        cur_wen;
  logic [31:0] cur_addr;
  logic [2:0]  cur_len;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_wmask;
  logic [1:0]  cur_off;
  logic [31:0] offset;
  logic [31:0] word_idx;
  logic [AW-1:0] mem_idx;
  logic [3:0]  len_sum;
  logic        addr_err;
  logic        rd_err;
  logic        wr_err;
  logic        err;
  logic        to_resp;
  logic        commit;
  logic [31:0] word;
  logic [31:0] wdata_sh;
  logic [3:0]  wmask_sh;
  logic [31:0] rdata_al;
  logic [31:0] resp_data;
  logic        unused_bits;

  assign req_ready = reset && (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // With zero latency the request is resolved on its own acceptance edge,
  // so the live inputs feed the datapath while idle.
  assign use_live  = (state == ST_IDLE);
  assign cur_wen   = use_live ? req_wen         : lat_wen;
  assign cur_addr  = use_live ? req_addr        : lat_addr;
  assign cur_len   = use_live ? req_len         : lat_len;
  assign cur_wdata = use_live ? req_wdata       : lat_wdata;
  assign cur_wmask = use_live ? req_wmask[3:0]  : lat_wmask;
  assign cur_off   = cur_addr[1:0];

  assign offset   = cur_addr - BASE;
  assign word_idx = {2'b00, offset[31:2]};
  assign mem_idx  = word_idx[AW-1:0];
  assign len_sum  = {2'b00, cur_off} + {1'b0, cur_len};

  assign addr_err = (cur_addr < BASE) || (word_idx >= DEPTH_W32);
  assign rd_err   = !cur_wen && (!len_legal(cur_len) || (len_sum > 4'd4));
  assign wr_err   = cur_wen && (cur_wmask != 4'd0) &&
                    (({1'b0, mask_top(cur_wmask)} + {1'b0, cur_off}) > 3'd3);
  assign err      = addr_err || rd_err || wr_err;

  assign to_resp = (accept && (LATENCY == 0)) || (state == ST_WAIT && cnt == 4'd0);
  assign commit  = to_resp && cur_wen && !err;

  assign word      = mem[mem_idx];
  assign resp_data = (err || cur_wen) ? 32'd0 : rdata_al;

  assign unused_bits = ^{req_wmask[7:4], offset[1:0]};

  pmem_lane_align u_align (
    .off      (cur_off),
    .len      (cur_len),
    .wdata    (cur_wdata),
    .wmask    (cur_wmask),
    .word     (word),
    .wdata_sh (wdata_sh),
    .wmask_sh (wmask_sh),
    .rdata    (rdata_al)
  );

  // Storage is deliberately left without reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_sh[b]) mem[mem_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
      lat_wen   <= 1'b0;
      lat_addr  <= 32'd0;
      lat_len   <= 3'd0;
      lat_wdata <= 32'd0;
      lat_wmask <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_wen   <= req_wen;
            lat_addr  <= req_addr;
            lat_len   <= req_len;
            lat_wdata <= req_wdata;
            lat_wmask <= req_wmask[3:0];
            if (LATENCY == 0) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= err;
              rsp_rdata <= resp_data;
            end else begin
              cnt   <= LAT_LOAD;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= resp_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: three instances (latency 2, 0, 3)
// share request fields; each has its own valid and response signals.
module tb_pmem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 256;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [2:0]        req_valid;
  logic [2:0]        req_ready;
  logic              req_wen;
  logic [31:0]       req_addr;
  logic [2:0]        req_len;
  logic [31:0]       req_wdata;
  logic [7:0]        req_wmask;
  logic [2:0]        rsp_valid;
  logic              rsp_ready;
  logic [2:0][31:0]  rsp_rdata;
  logic [2:0]        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_mem [int];

  always #5 clk = ~clk;

  pmem_responder #(.BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  pmem_responder #(.BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  pmem_responder #(.BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(3)) u_lat3 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wen(req_wen), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  function automatic int lat_of(input int inst);
    case (inst)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic calc_err(input logic wen, input logic [31:0] addr,
                                    input logic [2:0] len, input logic [7:0] wmask);
    logic [31:0] rel;
    int          off;
    rel = addr - BASE;
    off = int'(addr[1:0]);
    if (addr < BASE) return 1'b1;
    if ((rel >> 2) >= 32'(DEPTH)) return 1'b1;
    if (!wen) begin
      if (!(len == 3'd1 || len == 3'd2 || len == 3'd4)) return 1'b1;
      if (off + int'(len) > 4) return 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i] && (i + off > 3)) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Computes the expected response from the byte model and records it.
  task automatic push_exp(input int inst, input logic wen, input logic [31:0] addr,
                          input logic [2:0] len, input logic [31:0] wdata, input logic [7:0] wmask);
    exp_t e;
    int   key;
    e.err   = calc_err(wen, addr, len, wmask);
    e.rdata = 32'd0;
    if (!e.err) begin
      key = inst * 32'h0010_0000 + int'(addr - BASE);
      if (wen) begin
        for (int i = 0; i < 4; i++)
          if (wmask[i]) model_mem[key + i] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < int'(len); i++)
          e.rdata[8*i +: 8] = model_mem.exists(key + i) ? model_mem[key + i] : 8'h00;
      end
    end
    sb.push_back(e);
  endtask

  task automatic issue(input int inst, input logic wen, input logic [31:0] addr,
                       input logic [2:0] len, input logic [31:0] wdata, input logic [7:0] wmask);
    @(negedge clk);
    req_wen   = wen;
    req_addr  = addr;
    req_len   = len;
    req_wdata = wdata;
    req_wmask = wmask;
    req_valid = 3'b000;
    req_valid[inst] = 1'b1;
    chk("req_ready_idle", {31'd0, req_ready[inst]}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 3'b000;
  endtask

  task automatic await_rsp(input int inst, input string tag, input int stall);
    exp_t e;
    int   n;
    e = sb.pop_front();
    rsp_ready = (stall == 0);
    n = 0;
    @(negedge clk);
    while (!rsp_valid[inst] && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_cycles"}, 32'(n + 1), 32'(lat_of(inst) + 1));
    chk({tag, "_rdata"}, rsp_rdata[inst], e.rdata);
    chk({tag, "_err"}, {31'd0, rsp_err[inst]}, {31'd0, e.err});
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, rsp_valid[inst]}, 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata[inst], e.rdata);
      chk({tag, "_hold_ready"}, {31'd0, req_ready[inst]}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_valid"}, {31'd0, rsp_valid[inst]}, 32'd0);
    chk({tag, "_done_ready"}, {31'd0, req_ready[inst]}, 32'd1);
  endtask

  task automatic txn(input int inst, input string tag, input logic wen, input logic [31:0] addr,
                     input logic [2:0] len, input logic [31:0] wdata, input logic [7:0] wmask,
                     input int stall);
    push_exp(inst, wen, addr, len, wdata, wmask);
    issue(inst, wen, addr, len, wdata, wmask);
    await_rsp(inst, tag, stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 3'b000;
    req_wen   = 1'b0;
    req_addr  = 32'd0;
    req_len   = 3'd4;
    req_wdata = 32'd0;
    req_wmask = 8'd0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_req_ready", {31'd0, req_ready[i]}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid[i]}, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err[i]}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[i], 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("rel_req_ready", {31'd0, req_ready[i]}, 32'd1);

    // latency 2: full-word write then read back
    txn(0, "wr_dead", 1'b1, 32'h8000_0000, 3'd4, 32'hDEAD_BEEF, 8'h0F, 0);
    txn(0, "rd_dead", 1'b0, 32'h8000_0000, 3'd4, 32'd0, 8'h00, 0);

    // byte store into the middle of a word
    txn(0, "wr_base", 1'b1, 32'h8000_0000, 3'd4, 32'h1122_3344, 8'h0F, 0);
    txn(0, "wr_sb",   1'b1, 32'h8000_0002, 3'd4, 32'h0000_00AA, 8'h01, 0);
    txn(0, "rd_word", 1'b0, 32'h8000_0000, 3'd4, 32'd0, 8'h00, 0);
    txn(0, "rd_byte", 1'b0, 32'h8000_0002, 3'd1, 32'd0, 8'h00, 0);

    // rejected requests, then confirm storage untouched
    txn(0, "rd_below",  1'b0, 32'h7FFF_FFFC, 3'd4, 32'd0, 8'h00, 0);
    txn(0, "rd_above",  1'b0, BASE + 32'(4 * DEPTH), 3'd4, 32'd0, 8'h00, 0);
    txn(0, "rd_cross",  1'b0, 32'h8000_0003, 3'd2, 32'd0, 8'h00, 0);
    txn(0, "rd_len3",   1'b0, 32'h8000_0000, 3'd3, 32'd0, 8'h00, 0);
    txn(0, "wr_cross",  1'b1, 32'h8000_0003, 3'd4, 32'h0000_FFFF, 8'h03, 0);
    txn(0, "wr_above",  1'b1, BASE + 32'(4 * DEPTH), 3'd4, 32'h1234_5678, 8'h0F, 0);
    txn(0, "rd_intact", 1'b0, 32'h8000_0000, 3'd4, 32'd0, 8'h00, 0);

    // mask 0 is a no-op; upper mask bits are ignored; last word is in range
    txn(0, "wr_nomask", 1'b1, 32'h8000_0000, 3'd4, 32'hFFFF_FFFF, 8'h00, 0);
    txn(0, "wr_hibits", 1'b1, 32'h8000_0001, 3'd4, 32'h0000_0055, 8'hF1, 0);
    txn(0, "rd_after",  1'b0, 32'h8000_0000, 3'd4, 32'd0, 8'h00, 0);
    txn(0, "wr_last",   1'b1, BASE + 32'(4 * (DEPTH - 1)), 3'd4, 32'hA5A5_0F0F, 8'h0F, 0);
    txn(0, "rd_last",   1'b0, BASE + 32'(4 * (DEPTH - 1)) + 32'd2, 3'd2, 32'd0, 8'h00, 0);

    // response back-pressure
    txn(0, "rd_stall", 1'b0, 32'h8000_0000, 3'd4, 32'd0, 8'h00, 5);

    // zero latency
    txn(1, "l0_wr",   1'b1, 32'h8000_0008, 3'd4, 32'hCAFE_1234, 8'h0F, 0);
    txn(1, "l0_rd",   1'b0, 32'h8000_0008, 3'd4, 32'd0, 8'h00, 0);
    txn(1, "l0_half", 1'b0, 32'h8000_000A, 3'd2, 32'd0, 8'h00, 0);
    txn(1, "l0_err",  1'b0, 32'h8000_0009, 3'd4, 32'd0, 8'h00, 0);

    // latency 3: reset during the wait of a write drops it
    txn(2, "l3_wr", 1'b1, 32'h8000_0010, 3'd4, 32'h5566_7788, 8'h0F, 0);
    issue(2, 1'b1, 32'h8000_0010, 3'd4, 32'hCAFE_F00D, 8'h0F);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_valid", {31'd0, rsp_valid[2]}, 32'd0);
    chk("abort_ready", {31'd0, req_ready[2]}, 32'd0);
    chk("abort_rdata", rsp_rdata[2], 32'd0);
    chk("abort_err", {31'd0, rsp_err[2]}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rel_ready", {31'd0, req_ready[2]}, 32'd1);
    txn(2, "l3_rd_old", 1'b0, 32'h8000_0010, 3'd4, 32'd0, 8'h00, 0);
    txn(0, "rd_post_rst", 1'b0, 32'h8000_0000, 3'd4, 32'd0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
